// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential multiplier among N_REQ requesters.
// Define MULT_ARB_TIMEOUT_EN to add a watchdog that ends a stuck multiplier wait with rsp_err.
module mult_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 8
) (
    input  logic               clk,
    input  logic               clear,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] a_in,
    input  logic [N_REQ*W-1:0] b_in,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [2*W-1:0]     result,
    output logic               rsp_err,
    output logic               busy,
    output logic [W-1:0]       mul_A,
    output logic [W-1:0]       mul_B,
    output logic               mul_start,
    input  logic [2*W-1:0]     mul_out,
    input  logic               mul_done
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ZERO  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [IW-1:0]    last_r;
    logic [IW-1:0]    win_s;
    logic [W-1:0]     op_a_r;
    logic [W-1:0]     op_b_r;
    logic [W-1:0]     win_a_s;
    logic [W-1:0]     win_b_s;
    logic             found_s;
    logic             timeout_s;
    int               idx_s;
    logic [N_REQ-1:0] gnt_s;
    logic [N_REQ-1:0] rsp_valid_s;
    logic [2*W-1:0]   result_s;
    logic             rsp_err_s;
    logic             busy_s;
    logic             mul_start_s;

    function automatic logic [N_REQ-1:0] onehot_f(input logic [IW-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = {N_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search; walking downward lets the nearest requester after last_r overwrite the rest
    always_comb begin
        found_s = 1'b0;
        win_s   = last_r;
        win_a_s = {W{1'b0}};
        win_b_s = {W{1'b0}};
        idx_s   = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx_s   = (int'(last_r) + k) % N_REQ;
            found_s = found_s | req[idx_s];
            win_s   = req[idx_s] ? IW'(idx_s) : win_s;
            win_a_s = req[idx_s] ? a_in[idx_s*W +: W] : win_a_s;
            win_b_s = req[idx_s] ? b_in[idx_s*W +: W] : win_b_s;
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam logic [8:0] WD_LAST = 9'((1 << W) + 3);
    logic [8:0] wd_r;

    // Watchdog: counts cycles spent in WAIT, restarts on every other state
    always_ff @(posedge clk) begin
        if (clear) begin
            wd_r <= 9'd0;
        end else if (state_r == ST_WAIT) begin
            wd_r <= wd_r + 9'd1;
        end else begin
            wd_r <= 9'd0;
        end
    end

    assign timeout_s = (state_r == ST_WAIT) && !mul_done && (wd_r == WD_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // State register, arbitration pointer and operand latches
    always_ff @(posedge clk) begin
        if (clear) begin
            state_r <= ST_IDLE;
            last_r  <= IW'(N_REQ - 1);
            op_a_r  <= {W{1'b0}};
            op_b_r  <= {W{1'b0}};
        end else begin
            state_r <= state_s;
            if (state_r == ST_IDLE && found_s) begin
                last_r <= win_s;
                op_a_r <= win_a_s;
                op_b_r <= win_b_s;
            end
        end
    end

    // Next-state logic; mul_done is only trusted in WAIT because it may be stale elsewhere
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!found_s) begin
                    state_s = ST_IDLE;
                end else if (win_a_s == {W{1'b0}} || win_b_s == {W{1'b0}}) begin
                    state_s = ST_ZERO;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_ZERO:  state_s = ST_RESP;
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (mul_done || timeout_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle, keyed on the state being entered
    always_comb begin
        gnt_s       = {N_REQ{1'b0}};
        rsp_valid_s = {N_REQ{1'b0}};
        rsp_err_s   = 1'b0;
        mul_start_s = 1'b0;
        result_s    = result;
        busy_s      = (state_s != ST_IDLE);
        case (state_s)
            ST_ZERO: begin
                gnt_s = onehot_f(win_s);
            end
            ST_ISSUE: begin
                gnt_s       = onehot_f(win_s);
                mul_start_s = 1'b1;
            end
            ST_RESP: begin
                rsp_valid_s = onehot_f(last_r);
                rsp_err_s   = timeout_s;
                result_s    = (state_r == ST_WAIT && mul_done) ? mul_out : {(2*W){1'b0}};
            end
            default: begin
                busy_s = (state_s != ST_IDLE);
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (clear) begin
            gnt       <= {N_REQ{1'b0}};
            rsp_valid <= {N_REQ{1'b0}};
            rsp_err   <= 1'b0;
            mul_start <= 1'b0;
            result    <= {(2*W){1'b0}};
            busy      <= 1'b0;
        end else begin
            gnt       <= gnt_s;
            rsp_valid <= rsp_valid_s;
            rsp_err   <= rsp_err_s;
            mul_start <= mul_start_s;
            result    <= result_s;
            busy      <= busy_s;
        end
    end

    assign mul_A = op_a_r;
    assign mul_B = op_b_r;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: contract-following multiplier, timeline-based expected-output model,
// per-cycle comparison plus directed literal checks.
`timescale 1ns/1ps
module tb_mult_arbiter;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int INF = 32'h7fffffff;

    logic           clk = 1'b0;
    logic           clear = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] a_in = '0;
    logic [N*W-1:0] b_in = '0;
    logic [N-1:0]   gnt, rsp_valid;
    logic [2*W-1:0] result, mul_out;
    logic           rsp_err, busy, mul_start, mul_done;
    logic [W-1:0]   mul_A, mul_B;

    always #5 clk = ~clk;

    mult_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk(clk), .clear(clear), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .rsp_valid(rsp_valid), .result(result), .rsp_err(rsp_err),
        .busy(busy), .mul_A(mul_A), .mul_B(mul_B), .mul_start(mul_start),
        .mul_out(mul_out), .mul_done(mul_done)
    );

    // Multiplier following the contract: done rises B edges after the start edge, holds until next start
    logic [8:0]  mcnt = 9'd0;
    logic        mdone_r = 1'b0;
    logic [15:0] mprod = 16'd0;
    logic        hang = 1'b0;
    logic        force_done = 1'b0;

    always @(posedge clk) begin
        if (mul_start) begin
            mdone_r <= 1'b0;
            mcnt    <= hang ? 9'd0 : {1'b0, mul_B};
            mprod   <= 16'(mul_A) * 16'(mul_B);
        end else if (mcnt != 9'd0) begin
            mcnt <= mcnt - 9'd1;
            if (mcnt == 9'd1) mdone_r <= 1'b1;
        end
    end
    assign mul_done = mdone_r | force_done;
    assign mul_out  = mdone_r ? mprod : 16'hDEAD;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected-output model: one job record with its grant and response cycles
    bit          chk_en = 1'b0;
    bit          m_active = 1'b0;
    bit          m_nz = 1'b0;
    bit          m_err = 1'b0;
    bit          m_after_clear = 1'b0;
    int          m_win = 0, m_last = N - 1, m_gnt_cyc = 0, m_rsp_cyc = 0;
    logic [7:0]  m_a = 8'd0, m_b = 8'd0;
    logic [15:0] m_res = 16'd0, m_held = 16'd0;
    int          gnt_log[$];
    int          rsp_log[$];
    logic [15:0] res_log[$];
    int          start_cnt = 0;

    always @(negedge clk) begin
        int c, w, idx;
        logic [N-1:0] e_gnt, e_rv;
        logic e_err, e_start, e_busy;
        logic [15:0] e_res;
        if (chk_en) begin
            c = cyc;
            e_gnt = '0; e_rv = '0; e_err = 1'b0; e_start = 1'b0; e_res = m_held;
            e_busy = m_active && (c >= m_gnt_cyc);
            if (m_active && c == m_gnt_cyc) begin
                e_gnt[m_win] = 1'b1;
                e_start = m_nz;
            end
            if (m_active && c == m_rsp_cyc) begin
                e_rv[m_win] = 1'b1;
                e_err = m_err;
                e_res = m_res;
            end
            chk("gnt", 32'(gnt), 32'(e_gnt));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            chk("rsp_err", 32'(rsp_err), 32'(e_err));
            chk("mul_start", 32'(mul_start), 32'(e_start));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("result", 32'(result), 32'(e_res));
            if (m_active && m_nz && c >= m_gnt_cyc && c < m_rsp_cyc) begin
                chk("mul_A", 32'(mul_A), 32'(m_a));
                chk("mul_B", 32'(mul_B), 32'(m_b));
            end
            if (m_after_clear) begin
                chk("mul_A_clr", 32'(mul_A), 32'd0);
                chk("mul_B_clr", 32'(mul_B), 32'd0);
            end
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) gnt_log.push_back(i);
                if (rsp_valid[i]) begin
                    rsp_log.push_back(i);
                    res_log.push_back(result);
                end
            end
            if (mul_start) start_cnt++;

            m_after_clear = 1'b0;
            if (clear) begin
                m_active = 1'b0;
                m_last = N - 1;
                m_held = 16'd0;
                m_after_clear = 1'b1;
            end else if (m_active && c == m_rsp_cyc) begin
                m_held = m_res;
                m_active = 1'b0;
            end else if (!m_active && req != '0) begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (w < 0 && req[idx]) w = idx;
                end
                m_win = w; m_last = w;
                m_a = a_in[w*W +: W];
                m_b = b_in[w*W +: W];
                m_active = 1'b1;
                m_gnt_cyc = c + 1;
                m_nz = (m_a != 8'd0) && (m_b != 8'd0);
                m_err = 1'b0;
                if (!m_nz) begin
                    m_rsp_cyc = c + 2;
                    m_res = 16'd0;
                end else if (hang) begin
                    m_res = 16'd0;
`ifdef MULT_ARB_TIMEOUT_EN
                    m_rsp_cyc = c + 262;
                    m_err = 1'b1;
`else
                    m_rsp_cyc = INF;
`endif
                end else begin
                    m_rsp_cyc = c + int'(m_b) + 3;
                    m_res = 16'(m_a) * 16'(m_b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        tick(); clear = 1'b1;
        tick(); clear = 1'b0;
    endtask

    task automatic do_req(input int i, input logic [7:0] a, input logic [7:0] b, output int t0);
        bit got;
        tick();
        req[i] = 1'b1;
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
        t0 = cyc;
        got = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            if (gnt[i]) got = 1'b1;
        end
        chk("gnt_seen", 32'(got), 32'd1);
        tick();
        req[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int t0, input int maxc, output int rel, output logic [15:0] res, output logic err);
        rel = -1; res = 16'hFFFF; err = 1'b0;
        for (int n = 0; n < maxc && rel < 0; n++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                rel = cyc - t0;
                res = result;
                err = rsp_err;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1);
    end

    initial begin
        int t0, rel, sc0, n0, nr;
        logic [15:0] res;
        logic err;
        bit done5;

        // reset
        tick();
        chk_en = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_result", 32'(result), 32'd0);

        // single request 12*5
        sc0 = start_cnt;
        do_req(0, 8'd12, 8'd5, t0);
        wait_rsp(t0, 30, rel, res, err);
        chk("single_lat", 32'(rel), 32'd8);
        chk("single_res", 32'(res), 32'd60);
        chk("single_starts", 32'(start_cnt - sc0), 32'd1);

        // zero short-circuit
        sc0 = start_cnt;
        do_req(2, 8'd0, 8'd200, t0);
        wait_rsp(t0, 30, rel, res, err);
        chk("zeroA_lat", 32'(rel), 32'd2);
        chk("zeroA_res", 32'(res), 32'd0);
        do_req(2, 8'd255, 8'd0, t0);
        wait_rsp(t0, 30, rel, res, err);
        chk("zeroB_lat", 32'(rel), 32'd2);
        chk("zeroB_res", 32'(res), 32'd0);
        chk("zero_starts", 32'(start_cnt - sc0), 32'd0);

        // stale done during ISSUE (done also still high from the 12*5 job)
        tick();
        req[1] = 1'b1; a_in[1*W +: W] = 8'd6; b_in[1*W +: W] = 8'd3;
        t0 = cyc;
        tick(); force_done = 1'b1;
        tick(); force_done = 1'b0; req[1] = 1'b0;
        wait_rsp(t0, 30, rel, res, err);
        chk("stale_lat", 32'(rel), 32'd6);
        chk("stale_res", 32'(res), 32'd18);

        // round robin with all requests held
        do_clear();
        n0 = gnt_log.size();
        nr = rsp_log.size();
        tick();
        req = 4'b1111;
        a_in = {8'd7, 8'd10, 8'd3, 8'd255};
        b_in = {8'd9, 8'd2, 8'd4, 8'd255};
        done5 = 1'b0;
        for (int n = 0; n < 2000 && !done5; n++) begin
            @(negedge clk);
            if (gnt_log.size() >= n0 + 5) done5 = 1'b1;
        end
        chk("rr_five_grants", 32'(done5), 32'd1);
        tick();
        req = 4'b0000;
        for (int n = 0; n < 400 && busy; n++) @(negedge clk);
        chk("rr_idle", 32'(busy), 32'd0);
        if (gnt_log.size() >= n0 + 5) begin
            chk("rr_g0", 32'(gnt_log[n0]), 32'd0);
            chk("rr_g1", 32'(gnt_log[n0+1]), 32'd1);
            chk("rr_g2", 32'(gnt_log[n0+2]), 32'd2);
            chk("rr_g3", 32'(gnt_log[n0+3]), 32'd3);
            chk("rr_g4", 32'(gnt_log[n0+4]), 32'd0);
        end else begin
            chk("rr_grant_count", 32'(gnt_log.size() - n0), 32'd5);
        end
        if (rsp_log.size() >= nr + 5) begin
            chk("rr_r0_res", 32'(res_log[nr]), 32'd65025);
            chk("rr_r3_res", 32'(res_log[nr+3]), 32'd63);
        end else begin
            chk("rr_rsp_count", 32'(rsp_log.size() - nr), 32'd5);
        end

        // clear in the middle of WAIT
        do_req(0, 8'd1, 8'd100, t0);
        repeat (8) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_result", 32'(result), 32'd0);
        nr = rsp_log.size();
        repeat (120) tick();
        chk("clr_no_rsp", 32'(rsp_log.size() - nr), 32'd0);
        do_req(0, 8'd3, 8'd7, t0);
        wait_rsp(t0, 30, rel, res, err);
        chk("post_clr_lat", 32'(rel), 32'd10);
        chk("post_clr_res", 32'(res), 32'd21);

        // multiplier never finishes
        hang = 1'b1;
        do_req(3, 8'd9, 8'd9, t0);
`ifdef MULT_ARB_TIMEOUT_EN
        wait_rsp(t0, 300, rel, res, err);
        chk("tmo_lat", 32'(rel), 32'd262);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_res", 32'(res), 32'd0);
`else
        repeat (300) tick();
        @(negedge clk);
        chk("hang_busy", 32'(busy), 32'd1);
        chk("hang_err", 32'(rsp_err), 32'd0);
        do_clear();
`endif
        hang = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
